pdm_audio_input: RTL

Stereo PDM microphone receiver. It is the capture-side counterpart of the 1-bit delta-sigma audio output path.
- Generates the PDM bit clock for the microphones.
- Samples one shared PDM data line: left channel on one phase of the bit clock, right channel on the other.
- Decimates each channel with a 3rd-order CIC filter to signed PCM.
- Presents stereo samples to the Synthesijer-generated logic through a valid/ready holding register.

---
 rtl/pdm_audio_input.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pdm_audio_input.sv
// Stereo PDM microphone receiver: PDM clock generation, shared-line L/R capture,
// 3rd-order CIC decimation per channel, valid/ready output register. Define PDM_AUDIO_INPUT_MONO_EN for left-only capture.
module pdm_audio_input #(
  parameter int CLK_DIV   = 16,
  parameter int DEC_LOG2  = 5,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  output logic                        pdm_clk,
  input  logic                        pdm_data,
  output logic signed [OUT_WIDTH-1:0] sample_l,
  output logic signed [OUT_WIDTH-1:0] sample_r,
  output logic                        sample_valid,
  input  logic                        sample_ready,
  output logic                        overrun,
  input  logic                        clear_overrun
);

  localparam int ACC_W = 3*DEC_LOG2 + 2;
  localparam int SHIFT = 3*DEC_LOG2 + 1 - OUT_WIDTH;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef PDM_AUDIO_INPUT_MONO_EN
  localparam int unsigned NCH = 1;
`else
  localparam int unsigned NCH = 2;
`endif

  typedef logic signed [ACC_W-1:0] acc_t;
  localparam acc_t R3 = acc_t'(1) << (3*DEC_LOG2);

  logic [DIV_W-1:0]            r_div;
  logic                        r_pdm_clk;
  logic                        r_pdm_q;
`ifndef PDM_AUDIO_INPUT_MONO_EN
  logic                        r_primed;
`endif
  logic [DEC_LOG2-1:0]         r_dec_cnt;
  acc_t                        r_i1 [NCH];
  acc_t                        r_i2 [NCH];
  acc_t                        r_i3 [NCH];
  acc_t                        r_c0 [NCH];
  acc_t                        r_c1 [NCH];
  acc_t                        r_c2 [NCH];
  acc_t                        r_c3 [NCH];
  acc_t                        r_d1 [NCH];
  acc_t                        r_d2 [NCH];
  acc_t                        r_d3 [NCH];
  logic [3:0]                  r_stv;
  logic signed [OUT_WIDTH-1:0] r_smp [NCH];
  logic                        r_valid;
  logic                        r_overrun;

  logic                        w_wrap;
  logic                        w_cap_l;
  logic                        w_frame;
  logic                        w_dec;
  logic                        w_new;
  logic                        w_xfer;
  logic [NCH-1:0]              w_cap;
  acc_t                        w_x;
  acc_t                        w_i1n [NCH];
  acc_t                        w_i2n [NCH];
  acc_t                        w_i3n [NCH];
  acc_t                        w_dec_in [NCH];
  acc_t                        w_sat [NCH];
  logic signed [OUT_WIDTH-1:0] w_out [NCH];

  assign w_wrap  = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_cap_l = w_wrap && r_pdm_clk;

`ifdef PDM_AUDIO_INPUT_MONO_EN
  assign w_frame  = w_cap_l;
  assign w_cap    = w_cap_l;
  assign sample_r = '0;
`else
  // A right capture needs a preceding left one, so the low phase right after start-up is skipped.
  assign w_frame  = w_wrap && !r_pdm_clk && r_primed;
  assign w_cap    = {w_frame, w_cap_l};
  assign sample_r = r_smp[1];
`endif

  assign w_dec        = w_frame && (r_dec_cnt == '1);
  assign w_new        = r_stv[3];
  assign w_xfer       = r_valid && sample_ready;
  assign w_x          = r_pdm_q ? acc_t'(1) : '1;
  assign pdm_clk      = r_pdm_clk;
  assign sample_l     = r_smp[0];
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;

  always_comb begin
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      w_i1n[ch]    = r_i1[ch] + w_x;
      w_i2n[ch]    = r_i2[ch] + w_i1n[ch];
      w_i3n[ch]    = r_i3[ch] + w_i2n[ch];
      w_dec_in[ch] = w_cap[ch] ? w_i3n[ch] : r_i3[ch];
      w_sat[ch]    = (r_c3[ch] == R3) ? (R3 - acc_t'(1)) : r_c3[ch];
      w_out[ch]    = OUT_WIDTH'(w_sat[ch] >>> SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    r_pdm_q <= pdm_data;
    if (reset || !enable) begin
      r_div     <= '0;
      r_pdm_clk <= 1'b0;
`ifndef PDM_AUDIO_INPUT_MONO_EN
      r_primed  <= 1'b0;
`endif
      r_dec_cnt <= '0;
      r_stv     <= '0;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        r_i1[ch] <= '0;
        r_i2[ch] <= '0;
        r_i3[ch] <= '0;
        r_c0[ch] <= '0;
        r_c1[ch] <= '0;
        r_c2[ch] <= '0;
        r_c3[ch] <= '0;
        r_d1[ch] <= '0;
        r_d2[ch] <= '0;
        r_d3[ch] <= '0;
      end
    end else begin
      r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
      if (w_wrap) r_pdm_clk <= !r_pdm_clk;
`ifndef PDM_AUDIO_INPUT_MONO_EN
      if (w_cap_l) r_primed <= 1'b1;
`endif
      if (w_frame) r_dec_cnt <= r_dec_cnt + DEC_LOG2'(1);
      r_stv <= {r_stv[2:0], w_dec};
      // Comb delay registers advance only when their stage carries a decimated value.
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        if (w_cap[ch]) begin
          r_i1[ch] <= w_i1n[ch];
          r_i2[ch] <= w_i2n[ch];
          r_i3[ch] <= w_i3n[ch];
        end
        if (w_dec) r_c0[ch] <= w_dec_in[ch];
        if (r_stv[0]) begin
          r_c1[ch] <= r_c0[ch] - r_d1[ch];
          r_d1[ch] <= r_c0[ch];
        end
        if (r_stv[1]) begin
          r_c2[ch] <= r_c1[ch] - r_d2[ch];
          r_d2[ch] <= r_c1[ch];
        end
        if (r_stv[2]) begin
          r_c3[ch] <= r_c2[ch] - r_d3[ch];
          r_d3[ch] <= r_c2[ch];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      for (int unsigned ch = 0; ch < NCH; ch++) r_smp[ch] <= '0;
    end else begin
      if (w_new && (!r_valid || sample_ready)) begin
        r_valid <= 1'b1;
        for (int unsigned ch = 0; ch < NCH; ch++) r_smp[ch] <= w_out[ch];
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_new && r_valid && !sample_ready) r_overrun <= 1'b1;
      else if (clear_overrun)                r_overrun <= 1'b0;
    end
  end

endmodule
